// File: rtl/lsu_pkg.sv
// Shared types and sizing constants for the load/store unit and its response register.
package lsu_pkg;

  localparam int unsigned LSU_MEM_WORDS = 8;
  localparam int unsigned LSU_DATA_W    = 8;
  localparam int unsigned LSU_RD_W      = 3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STORE      = 3'd1,
    LOAD_ISSUE = 3'd2,
    LOAD_WAIT  = 3'd3,
    RESP       = 3'd4
  } lsu_state_t;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned words);
    return addr < words;
  endfunction

endpackage

// File: rtl/lsu_resp_reg.sv
// Writeback response register: captures destination index and load data on 'load',
// otherwise holds its value so a stalled response stays stable.
module lsu_resp_reg
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = LSU_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [LSU_RD_W-1:0] rd_in,
  input  logic [DATA_W-1:0]   data_in,
  output logic [LSU_RD_W-1:0] rd_out,
  output logic [DATA_W-1:0]   data_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_out   <= '0;
      data_out <= '0;
    end else if (load) begin
      rd_out   <= rd_in;
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and a data memory
// with registered read data; out-of-range requests raise a one-cycle fault pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = LSU_MEM_WORDS,
  parameter int unsigned DATA_W    = LSU_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [DATA_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [LSU_RD_W-1:0] req_rd,
  output logic                mem_enable,
  output logic [DATA_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W-1:0]   mem_data_out,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [LSU_RD_W-1:0] wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic                fault,
  output lsu_state_t          state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds its payload stable while valid is high and ready is low.
  lsu_state_t              state_q, state_d;
  logic [DATA_W-1:0]       addr_q, data_q;
  logic [LSU_RD_W-1:0]     rd_q;
  logic                    fault_q;
  logic                    accept, in_range;

  assign req_ready = (state_q == IDLE);
  assign wb_valid  = (state_q == RESP);
  assign fault     = fault_q;
  assign state_dbg = state_q;
  assign accept    = req_valid && req_ready;
  assign in_range  = addr_in_range(32'(req_addr), MEM_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= accept && !in_range;
      if (accept) begin
        addr_q <= req_addr;
        data_q <= req_data;
        rd_q   <= req_rd;
      end
    end
  end

  // The load/store choice is folded into the state, so req_write need not be kept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept && in_range) state_d = req_write ? STORE : LOAD_ISSUE;
      STORE:      state_d = IDLE;
      LOAD_ISSUE: state_d = LOAD_WAIT;
      LOAD_WAIT:  state_d = RESP;
      RESP:       if (wb_ready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_enable  = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (state_q)
      STORE: begin
        mem_enable  = 1'b1;
        mem_address = addr_q;
        mem_data_in = data_q;
      end
      // The memory expects the read address on its data port as well during loads.
      LOAD_ISSUE, LOAD_WAIT: begin
        mem_address = addr_q;
        mem_data_in = addr_q;
      end
      default: ;
    endcase
  end

  lsu_resp_reg #(.DATA_W(DATA_W)) u_resp (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == LOAD_WAIT),
    .rd_in    (rd_q),
    .data_in  (mem_data_out),
    .rd_out   (wb_rd),
    .data_out (wb_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, hand-written multi-cycle sequences and
// random traffic checked against a word-array reference model via expected queues.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic       clk, rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_data;
  logic [2:0] req_rd;
  logic       mem_enable;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic       wb_valid, wb_ready;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       fault;
  lsu_state_t state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_wr_q[$];
  logic [10:0] exp_wb_q[$];
  logic [15:0] mon_wr;
  logic [10:0] mon_wb;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [LSU_MEM_WORDS];

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_rd(req_rd),
    .mem_enable(mem_enable), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / memory ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (mem_enable) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain word array; each accepted request yields its expectations.
  task automatic model_accept(input logic w, input logic [7:0] a, input logic [7:0] d,
                              input logic [2:0] rd);
    if (int'(a) < int'(LSU_MEM_WORDS)) begin
      if (w) begin
        ref_mem[a[2:0]] = d;
        exp_wr_q.push_back({a, d});
      end else begin
        exp_wb_q.push_back({rd, ref_mem[a[2:0]]});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [2:0] rd);
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    req_rd    = rd;
    while (!req_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: req_ready 0, required 1");
    end
    model_accept(w, a, d, rd);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_ready);
    int n;
    n = 0;
    while (!req_ready && n < 40) begin
      if (rnd_ready) wb_ready = (n > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: req_ready 0, required 1");
    end
    wb_ready = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_enable) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mon_write: unexpected write addr 0x%0h data 0x%0h, required none",
                   mem_address, mem_data_in);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          check("mon_write", 32'({mem_address, mem_data_in}), 32'(mon_wr));
        end
      end
      if (wb_valid && wb_ready) begin
        if (exp_wb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mon_wb: unexpected writeback rd %0d data 0x%0h, required none",
                   wb_rd, wb_data);
        end else begin
          mon_wb = exp_wb_q.pop_front();
          check("mon_wb", 32'({wb_rd, wb_data}), 32'(mon_wb));
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       w;
    logic [7:0] addr;
    logic [7:0] data;
    logic [2:0] rd;
    logic       exp_fault;
    logic       exp_en;
    logic [7:0] exp_maddr;
    logic [7:0] exp_mdin;
    logic [7:0] exp_wb;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    vec_t       v;
    logic       w;
    logic [7:0] a, d, exp_d;
    logic [2:0] rd;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    for (int i = 0; i < int'(LSU_MEM_WORDS); i++) ref_mem[i] = 8'(i * 37 + 11);

    //          w     addr   data   rd    flt   en    maddr  mdin   wb
    vecs[0]  = '{1'b1, 8'd3,  8'hA5, 3'd0, 1'b0, 1'b1, 8'd3,  8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 8'd3,  8'h00, 3'd2, 1'b0, 1'b0, 8'd3,  8'd3,  8'hA5};
    vecs[2]  = '{1'b1, 8'd7,  8'h3C, 3'd0, 1'b0, 1'b1, 8'd7,  8'h3C, 8'h00};
    vecs[3]  = '{1'b0, 8'd7,  8'h00, 3'd5, 1'b0, 1'b0, 8'd7,  8'd7,  8'h3C};
    vecs[4]  = '{1'b1, 8'd0,  8'hFF, 3'd0, 1'b0, 1'b1, 8'd0,  8'hFF, 8'h00};
    vecs[5]  = '{1'b0, 8'd0,  8'h00, 3'd7, 1'b0, 1'b0, 8'd0,  8'd0,  8'hFF};
    vecs[6]  = '{1'b0, 8'd9,  8'h00, 3'd1, 1'b1, 1'b0, 8'd0,  8'd0,  8'h00};
    vecs[7]  = '{1'b1, 8'd8,  8'h11, 3'd0, 1'b1, 1'b0, 8'd0,  8'd0,  8'h00};
    vecs[8]  = '{1'b0, 8'd3,  8'h00, 3'd0, 1'b0, 1'b0, 8'd3,  8'd3,  8'hA5};
    vecs[9]  = '{1'b1, 8'd3,  8'h5A, 3'd0, 1'b0, 1'b1, 8'd3,  8'h5A, 8'h00};
    vecs[10] = '{1'b0, 8'd3,  8'h00, 3'd6, 1'b0, 1'b0, 8'd3,  8'd3,  8'h5A};
    vecs[11] = '{1'b1, 8'hFF, 8'h77, 3'd0, 1'b1, 1'b0, 8'd0,  8'd0,  8'h00};

    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_rd    = '0;
    wb_ready  = 1'b1;
    rst       = 1'b1;

    // Reset values
    tick();
    tick();
    check("rst_mem_enable",  32'(mem_enable),  32'(0));
    check("rst_mem_address", 32'(mem_address), 32'(0));
    check("rst_mem_data_in", 32'(mem_data_in), 32'(0));
    check("rst_wb_valid",    32'(wb_valid),    32'(0));
    check("rst_wb_rd",       32'(wb_rd),       32'(0));
    check("rst_wb_data",     32'(wb_data),     32'(0));
    check("rst_fault",       32'(fault),       32'(0));
    rst = 1'b0;
    tick();
    check("rst_req_ready",   32'(req_ready),   32'(1));

    // Table-driven single transactions
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      send(v.w, v.addr, v.data, v.rd);
      check($sformatf("v%0d_fault", i),       32'(fault),       32'(v.exp_fault));
      check($sformatf("v%0d_mem_enable", i),  32'(mem_enable),  32'(v.exp_en));
      check($sformatf("v%0d_mem_address", i), 32'(mem_address), 32'(v.exp_maddr));
      check($sformatf("v%0d_mem_data_in", i), 32'(mem_data_in), 32'(v.exp_mdin));
      if (v.exp_fault) begin
        check($sformatf("v%0d_ready", i),    32'(req_ready), 32'(1));
        check($sformatf("v%0d_wb_valid", i), 32'(wb_valid),  32'(0));
        tick();
        check($sformatf("v%0d_fault_end", i),  32'(fault),      32'(0));
        check($sformatf("v%0d_no_write", i),   32'(mem_enable), 32'(0));
      end else if (v.w) begin
        tick();
        check($sformatf("v%0d_store_end", i), 32'(mem_enable), 32'(0));
        check($sformatf("v%0d_ready", i),     32'(req_ready),  32'(1));
      end else begin
        check($sformatf("v%0d_wb_early1", i), 32'(wb_valid), 32'(0));
        tick();
        check($sformatf("v%0d_wait_addr", i), 32'(mem_address), 32'(v.addr));
        check($sformatf("v%0d_wb_early2", i), 32'(wb_valid),    32'(0));
        tick();
        check($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(1));
        check($sformatf("v%0d_wb_rd", i),    32'(wb_rd),    32'(v.rd));
        check($sformatf("v%0d_wb_data", i),  32'(wb_data),  32'(v.exp_wb));
        tick();
        check($sformatf("v%0d_ready", i),    32'(req_ready), 32'(1));
        check($sformatf("v%0d_wb_done", i),  32'(wb_valid),  32'(0));
      end
    end

    // Stalled writeback: wb_ready low for 4 cycles
    wb_ready = 1'b0;
    exp_d    = ref_mem[5];
    send(1'b0, 8'd5, 8'h00, 3'd4);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check("stall_wb_valid",  32'(wb_valid),  32'(1));
      check("stall_wb_data",   32'(wb_data),   32'(exp_d));
      check("stall_wb_rd",     32'(wb_rd),     32'(4));
      check("stall_req_ready", 32'(req_ready), 32'(0));
      if (k == 3) wb_ready = 1'b1;
      tick();
    end
    check("stall_release_ready", 32'(req_ready), 32'(1));
    check("stall_release_state", 32'(state_dbg), 32'(IDLE));
    check("stall_release_wb",    32'(wb_valid),  32'(0));

    // Back-to-back stores with req_valid held high
    req_valid = 1'b1;
    req_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 8'(i);
      req_data = 8'($urandom_range(0, 255));
      check("b2b_ready_idle", 32'(req_ready), 32'(1));
      model_accept(1'b1, req_addr, req_data, 3'd0);
      tick();
      check("b2b_mem_enable",  32'(mem_enable),  32'(1));
      check("b2b_mem_address", 32'(mem_address), 32'(i));
      check("b2b_ready_busy",  32'(req_ready),   32'(0));
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 8'(i), 8'h00, 3'(i));
      wait_idle(1'b0);
    end

    // Reset in the middle of LOAD_WAIT
    send(1'b0, 8'd2, 8'h00, 3'd3);
    tick();
    check("rstmid_state", 32'(state_dbg), 32'(LOAD_WAIT));
    rst = 1'b1;
    exp_wb_q.delete();
    #1;
    check("rstmid_state_idle",  32'(state_dbg),   32'(IDLE));
    check("rstmid_mem_enable",  32'(mem_enable),  32'(0));
    check("rstmid_mem_address", 32'(mem_address), 32'(0));
    check("rstmid_mem_data_in", 32'(mem_data_in), 32'(0));
    check("rstmid_wb_valid",    32'(wb_valid),    32'(0));
    check("rstmid_wb_rd",       32'(wb_rd),       32'(0));
    check("rstmid_wb_data",     32'(wb_data),     32'(0));
    check("rstmid_fault",       32'(fault),       32'(0));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rstmid_no_wb", 32'(wb_valid), 32'(0));
    end

    // req_valid toggling while a load is in flight
    exp_d = ref_mem[6];
    send(1'b0, 8'd6, 8'h00, 3'd1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'd2;
    req_data  = 8'hEE;
    check("tog_state_issue", 32'(state_dbg),   32'(LOAD_ISSUE));
    check("tog_addr_issue",  32'(mem_address), 32'(6));
    #2 req_valid = 1'b0;
    #2 req_valid = 1'b1;
    tick();
    check("tog_addr_wait", 32'(mem_address), 32'(6));
    check("tog_data_wait", 32'(mem_data_in), 32'(6));
    req_valid = 1'b0;
    tick();
    check("tog_wb_data", 32'(wb_data), 32'(exp_d));
    check("tog_wb_rd",   32'(wb_rd),   32'(1));
    tick();
    check("tog_ready",      32'(req_ready), 32'(1));
    tick();
    check("tog_still_idle", 32'(state_dbg), 32'(IDLE));

    // Random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 11));
      d  = 8'($urandom_range(0, 255));
      rd = 3'($urandom_range(0, 7));
      send(w, a, d, rd);
      check("rnd_fault", 32'(fault), 32'(int'(a) >= int'(LSU_MEM_WORDS)));
      wait_idle(1'b1);
    end
    tick();
    tick();

    check("end_write_queue_empty", 32'(exp_wr_q.size()), 32'(0));
    check("end_wb_queue_empty",    32'(exp_wb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 8, number of implemented data-memory words; addresses >= MEM_WORDS are out of range.
REQ-002 Parameter DATA_W, default 8, data and address width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  execute stage presents a memory request.
REQ-006 req_ready  output  1  unit can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  8  word address.
REQ-009 req_data  input  8  store data.
REQ-010 req_rd  input  3  destination register index for loads.
REQ-011 mem_enable  output  1  data-memory write enable; 0 means the memory performs a read.
REQ-012 mem_address  output  8  data-memory address.
REQ-013 mem_data_in  output  8  data-memory write data; carries the read address during loads.
REQ-014 mem_data_out  input  8  data-memory registered read data.
REQ-015 wb_valid  output  1  load result available for writeback.
REQ-016 wb_ready  input  1  writeback stage accepts the result.
REQ-017 wb_rd  output  3  destination register of the result.
REQ-018 wb_data  output  8  loaded value.
REQ-019 fault  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-020 FSM states: IDLE, STORE, LOAD_ISSUE, LOAD_WAIT, RESP.
REQ-021 req_ready = 1 only in IDLE; handshake when req_valid && req_ready at a rising edge.
REQ-022 The accepted request (write, addr, data, rd) is latched; inputs are ignored outside IDLE.
REQ-023 Out-of-range accepted request: fault = 1 the next cycle, no memory write, no writeback, FSM stays in IDLE.
REQ-024 Store: IDLE -> STORE; in STORE, mem_enable = 1, mem_address = addr, mem_data_in = data for exactly one cycle; STORE -> IDLE.
REQ-025 Load: IDLE -> LOAD_ISSUE; in LOAD_ISSUE, mem_enable = 0 and mem_address = mem_data_in = addr; LOAD_ISSUE -> LOAD_WAIT.
REQ-026 In LOAD_WAIT, mem_data_out is captured into wb_data with the same address still driven; LOAD_WAIT -> RESP.
REQ-027 In RESP, wb_valid = 1 and wb_rd/wb_data are stable; RESP -> IDLE on the edge where wb_ready = 1.
REQ-028 Load latency: wb_valid asserts 3 cycles after the accepting edge; store occupies 1 cycle after acceptance; throughput is one outstanding request.
REQ-029 Outside STORE, mem_enable = 0; in IDLE and RESP, mem_address and mem_data_in hold 0.
REQ-030 wb_valid held under wb_ready = 0 for any duration, with no change to wb_rd/wb_data.
REQ-031 Store followed immediately by a load to the same address returns the stored value.

Reset
REQ-032 On rst the FSM enters IDLE and all latched request fields clear to 0, asynchronously and independent of clk.
REQ-033 Reset values: req_ready = 1 (on release), mem_enable = 0, mem_address = 0, mem_data_in = 0, wb_valid = 0, wb_rd = 0, wb_data = 0, fault = 0.
REQ-034 Reset during STORE, LOAD_ISSUE, LOAD_WAIT, or RESP abandons the operation; no write and no writeback follow.

Structure
REQ-035 Shared package lsu_pkg holds the FSM state type, MEM_WORDS, DATA_W, and the register-index width constant (3).
REQ-036 One sub-module, lsu_resp_reg, holds the wb_rd/wb_data response register with a load enable and hold-under-stall behaviour; all other logic stays in load_store_unit.

Verification
REQ-037 Store addr 3 data 0xA5, then load addr 3 rd 2 -> mem_enable high for one cycle with address 3/data 0xA5; wb_valid 3 cycles after load accept with wb_rd = 2 and wb_data = 0xA5.
REQ-038 Load addr 9 -> fault pulse 1 cycle, mem_enable stays 0, wb_valid stays 0, req_ready = 1 the following cycle.
REQ-039 Load addr 5 with wb_ready held 0 for 4 cycles -> wb_valid/wb_data stable for 4 cycles, req_ready = 0, IDLE one cycle after wb_ready = 1.
REQ-040 req_valid held high with back-to-back stores to addr 0..7 -> each accepted every 2 cycles, and all 8 words written in order.
REQ-041 rst asserted mid-LOAD_WAIT -> all outputs take their reset values immediately; no wb_valid after release.
REQ-042 req_valid toggling while in LOAD_ISSUE -> no extra handshake; latched address is unchanged.
